mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between the instruction-fetch stage (IF) and the memory-access stage (MEM).
- Serialises each 1/2/4-byte transfer into consecutive byte cycles and assembles read data little-endian.
- Returns one-cycle done pulses to the requesters.
- Sits between the IF/MEM stages and the external RAM. The pipeline stall logic holds a stage stalled while its request is outstanding.

Parameters:
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  branch flush; aborts an in-flight IF access
- if_req  in  1  IF fetch request, held until if_done
- if_addr  in  32  fetch address
- if_data  out  32  fetched word
- if_done  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_len  in  2  bytes-1 (0=byte, 1=half, 3=word; 2 treated as 3)
- mem_addr  in  32  data address
- mem_wdata  in  32  store data, byte0 = bits 7:0
- mem_rdata  out  32  load data, zero-extended
- mem_done  out  1  one-cycle completion pulse for MEM
- ram_addr  out  32  RAM byte address (registered)
- ram_wr  out  1  RAM write strobe (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte
- busy  out  1  state != IDLE
- if_cnt  out  32  completed IF transactions (feature only)
- mem_cnt  out  32  completed MEM transactions (feature only)

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Reset forces:
  - all outputs to 0;
  - state to IDLE and byte counter to 0.
  Reset mid-transfer abandons it with no done pulse.
- RAM timing: the byte for the address on ram_addr in cycle t appears on ram_din in cycle t+1. A write occurs in any cycle with ram_wr=1.
- States: IDLE, RD, WR, DONE. Latched: owner (IF/MEM), base address A, N = mem_len+1 (IF: N=4), wdata, cnt[2:0].
- IDLE acceptance:
  - mem_req=1: MEM wins (fixed priority); go to WR if mem_we, else RD.
  - else if_req=1 and flush=0: go to RD, owner IF.
  - On accept, latch the request fields and set cnt=0.
- RD:
  - ram_addr = A+cnt during issue cycles cnt = 0..N-1.
  - Byte k is captured from ram_din one cycle later into bits 8k+7:8k.
  - After the last byte is captured, go to DONE.
  - Load latency from the request-accepting edge to the done cycle is N+2 cycles; word = 6.
- WR:
  - cycles 1..N: ram_wr=1, ram_addr=A+k, ram_dout = wdata byte k;
  - then DONE; ram_wr=0 outside WR.
- DONE, one cycle:
  - assert the owner's done pulse;
  - if_data/mem_rdata hold the assembled value until overwritten by the next completed read of that owner;
  - next state IDLE.
  - No request is accepted in DONE. A requester drops req at the edge ending DONE.
- Unused upper bytes of mem_rdata are 0 for N<4.
- Address arithmetic is modulo 2^32; A=0xFFFFFFFF wraps to 0.
- flush:
  - In RD with owner IF, go to IDLE next edge; no if_done, if_data unchanged.
  - flush in IDLE blocks IF acceptance that cycle.
  - flush has no effect on MEM transfers or on IF in DONE (pulse still issued).
- MEM requests arriving during an IF transfer wait; there is no preemption.
- IF cannot starve MEM: MEM always wins in IDLE.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - if_cnt and mem_cnt increment by 1 in each DONE cycle of the respective owner;
  - they wrap at 2^32 and clear on rst;
  - aborted (flushed) IF transfers are not counted.
- Undefined: both ports are tied to 0 and no counter registers exist.

Test Plan:
- Word fetch: RAM[0x100..0x103] = 0x13,0x05,0x10,0x00; if_req, if_addr=0x100 -> ram_addr 0x100..0x103 consecutively; if_done one pulse 6 cycles after accept; if_data=0x00100513.
- Byte store: mem_req, mem_we=1, mem_len=0, mem_addr=0x20, mem_wdata=0xAABBCCDD -> exactly one ram_wr cycle, addr 0x20, dout 0xDD; mem_done next cycle.
- Half load: RAM[0x40]=0x34, RAM[0x41]=0x12, mem_len=1 -> mem_rdata=0x00001234; mem_done at accept+4.
- Priority: if_req and mem_req both rise in the same IDLE cycle -> MEM served first, IF accepted in the IDLE after MEM's DONE; if_done follows.
- Flush: flush=1 during the 2nd byte of an IF read -> no if_done, busy=0 next cycle, if_data unchanged; with ARB_STATS_EN, if_cnt unchanged.
- Reset mid-store: rst after the 2nd byte of a word store -> ram_wr=0, busy=0, no mem_done; a fresh request afterwards completes normally; wrap case A=0xFFFFFFFE word read -> addresses FE, FF, 0, 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter for the IF and MEM stages (MEM has fixed priority).
// Define ARB_STATS_EN to enable the if_cnt/mem_cnt completed-transaction counters.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy,
    output logic [31:0]       if_cnt,
    output logic [31:0]       mem_cnt
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt, n, len_n, cnt_inc;
    logic              own_mem, accept;
    logic [ADDR_W-1:0] base, addr_inc;
    logic [31:0]       wdata, rbuf, rd_word;
    logic [1:0]        cap_sel, wr_sel;

    always_comb begin
        case (mem_len)
            2'd0:    len_n = 3'd1;
            2'd1:    len_n = 3'd2;
            default: len_n = 3'd4;
        endcase
    end

    assign cnt_inc  = cnt + 3'd1;
    assign addr_inc = base + ADDR_W'(cnt_inc);
    assign cap_sel  = 2'(cnt - 3'd1);
    assign wr_sel   = cnt_inc[1:0];

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mem_req)              state_nx = mem_we ? WR : RD;
                else if (if_req && !flush) state_nx = RD;
            end
            RD: begin
                if (flush && !own_mem) state_nx = IDLE;
                else if (cnt == n)     state_nx = DONE;
            end
            WR:      if (cnt_inc == n) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && (state_nx != IDLE);

    // Byte k (issued in cycle cnt=k) arrives one cycle later, i.e. while cnt=k+1.
    always_comb begin
        rd_word = rbuf;
        if (state == RD && cnt != 3'd0) rd_word[{cap_sel, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            own_mem <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= 3'd0;
                own_mem <= mem_req;
            end else if (state == RD || state == WR) begin
                cnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (accept) begin
            ram_addr <= mem_req ? mem_addr : if_addr;
            ram_wr   <= mem_req && mem_we;
            ram_dout <= mem_wdata[7:0];
        end else begin
            case (state)
                RD: begin
                    if (cnt_inc < n) ram_addr <= addr_inc;
                    if (state_nx == DONE) begin
                        if (own_mem) mem_rdata <= rd_word;
                        else         if_data   <= rd_word;
                    end
                end
                WR: begin
                    if (state_nx == DONE) begin
                        ram_wr <= 1'b0;
                    end else begin
                        ram_addr <= addr_inc;
                        ram_dout <= wdata[{wr_sel, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    // Request fields latched at accept; no reset needed on pure data.
    always_ff @(posedge clk) begin
        if (accept) begin
            base  <= mem_req ? mem_addr : if_addr;
            n     <= mem_req ? len_n : 3'd4;
            wdata <= mem_wdata;
            rbuf  <= 32'd0;
        end else if (state == RD) begin
            rbuf <= rd_word;
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        if_done  = (state == DONE) && !own_mem;
        mem_done = (state == DONE) && own_mem;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_cnt  <= 32'd0;
            mem_cnt <= 32'd0;
        end else if (state == DONE) begin
            if (own_mem) mem_cnt <= mem_cnt + 32'd1;
            else         if_cnt  <= if_cnt + 32'd1;
        end
    end
`else
    assign if_cnt  = 32'd0;
    assign mem_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table with scoreboard plus
// hand-written priority, flush and reset-mid-store sequences.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush, if_req, if_done, mem_req, mem_we, mem_done, ram_wr, busy;
    logic [1:0]  mem_len;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_addr, if_cnt, mem_cnt;
    logic [7:0]  ram_dout, ram_din;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy(busy), .if_cnt(if_cnt), .mem_cnt(mem_cnt)
    );

    always #5 clk = ~clk;

    // RAM model, 4 KiB aliased on the low 12 address bits, one-cycle read latency
    logic [7:0]  ram [4096];
    logic        pl_we;
    logic [11:0] pl_addr;
    logic [7:0]  pl_data;
    always @(posedge clk) begin
        if (pl_we)       ram[pl_addr] <= pl_data;
        else if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
        ram_din <= ram[ram_addr[11:0]];
    end

    int n_vec = 0, n_bad = 0;
    int n_if_done = 0, n_mem_done = 0;
    always @(posedge clk) begin
        if (rst) begin
            n_if_done  = 0;
            n_mem_done = 0;
        end else begin
            if (if_done)  n_if_done++;
            if (mem_done) n_mem_done++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pl(input logic [11:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic run_txn(input vec_t v, input string name);
        int nb, lat;
        bit got;
        exp_t e;
        logic [31:0] a;
        nb  = v.is_if ? 4 : (v.len == 2'd0 ? 1 : (v.len == 2'd1 ? 2 : 4));
        lat = v.we ? nb + 1 : nb + 2;
        sb.push_back('{v.exp, lat});
        @(posedge clk); #1;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            mem_req = 1'b1; mem_we = v.we; mem_len = v.len;
            mem_addr = v.addr; mem_wdata = v.wdata;
        end
        got = 1'b0;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(posedge clk); #1;
            if (k <= nb) begin
                check({name, ":addr"}, ram_addr, v.addr + 32'(k - 1));
                if (v.we) check({name, ":dout"}, {24'h0, ram_dout}, {24'h0, v.wdata[8*(k-1) +: 8]});
            end
            check({name, ":wr"}, {31'h0, ram_wr}, (v.we && k <= nb) ? 32'd1 : 32'd0);
            if (v.is_if ? if_done : mem_done) begin
                got = 1'b1;
                e = sb.pop_front();
                check({name, ":latency"}, 32'(k), 32'(e.lat));
                if (!v.we) check({name, ":data"}, v.is_if ? if_data : mem_rdata, e.data);
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL %s: no done pulse within 30 cycles", name);
            void'(sb.pop_front());
            if_req = 1'b0; mem_req = 1'b0;
        end
        if (v.we) begin
            for (int j = 0; j < nb; j++) begin
                a = v.addr + 32'(j);
                check({name, ":ram"}, {24'h0, ram[a[11:0]]}, {24'h0, v.wdata[8*j +: 8]});
            end
        end
    endtask

    vec_t vt[10];
    logic [31:0] prev;
    int kd;
    bit seen;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clk);
        #1;
        pl(12'h100, 8'h13); pl(12'h101, 8'h05); pl(12'h102, 8'h10); pl(12'h103, 8'h00);
        pl(12'h040, 8'h34); pl(12'h041, 8'h12); pl(12'h020, 8'h00); pl(12'h021, 8'h99);
        pl(12'h092, 8'hEE); pl(12'h093, 8'h00); pl(12'h302, 8'h00);
        pl(12'hFFE, 8'h11); pl(12'hFFF, 8'h22); pl(12'h000, 8'h33); pl(12'h001, 8'h44);
        @(posedge clk); #1;
        check("reset:busy", {31'h0, busy}, 32'd0);
        check("reset:done", {30'h0, if_done, mem_done}, 32'd0);
        check("reset:ram_wr", {31'h0, ram_wr}, 32'd0);
        check("reset:ram_addr", ram_addr, 32'd0);
        check("reset:if_data", if_data, 32'd0);
        check("reset:mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;

        vt[0] = '{1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,           32'h0010_0513};
        vt[1] = '{1'b0, 1'b1, 2'd0, 32'h0000_0020, 32'hAABB_CCDD,   32'h0};
        vt[2] = '{1'b0, 1'b0, 2'd1, 32'h0000_0040, 32'h0,           32'h0000_1234};
        vt[3] = '{1'b0, 1'b1, 2'd3, 32'h0000_0080, 32'hDEAD_BEEF,   32'h0};
        vt[4] = '{1'b0, 1'b0, 2'd3, 32'h0000_0080, 32'h0,           32'hDEAD_BEEF};
        vt[5] = '{1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'h0,           32'hDEAD_BEEF};
        vt[6] = '{1'b0, 1'b0, 2'd0, 32'h0000_0083, 32'h0,           32'h0000_00DE};
        vt[7] = '{1'b0, 1'b1, 2'd1, 32'h0000_0090, 32'h1234_5678,   32'h0};
        vt[8] = '{1'b0, 1'b0, 2'd3, 32'h0000_0090, 32'h0,           32'h00EE_5678};
        vt[9] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,           32'h4433_2211};
        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i], $sformatf("vec%0d", i));
            if (i == 1) check("vec1:neighbour", {24'h0, ram[12'h021]}, 32'h0000_0099);
        end

        // Priority: both requests in the same IDLE cycle
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h40;
        kd = 0; seen = 1'b0;
        for (int k = 1; k <= 40 && kd == 0; k++) begin
            @(posedge clk); #1;
            if (if_done) seen = 1'b1;
            if (mem_done) begin
                kd = k;
                mem_req = 1'b0;
                check("prio:mem_latency", 32'(k), 32'd3);
                check("prio:mem_rdata", mem_rdata, 32'h0000_0034);
            end
        end
        check("prio:if_before_mem", {31'h0, seen}, 32'd0);
        for (int k = kd + 1; k <= kd + 40 && if_req; k++) begin
            @(posedge clk); #1;
            if (if_done) begin
                if_req = 1'b0;
                check("prio:if_latency", 32'(k), 32'(kd + 7));
                check("prio:if_data", if_data, 32'h0010_0513);
            end
        end
        if (if_req) begin
            n_vec++; n_bad++;
            $display("FAIL prio: if_done never arrived");
            if_req = 1'b0;
        end

        // Flush during the second byte of an IF fetch
        @(posedge clk); #1;
        prev = if_data;
        kd = n_if_done;
        if_req = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush:busy", {31'h0, busy}, 32'd0);
        flush = 1'b0; if_req = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if_done) seen = 1'b1;
        end
        check("flush:no_done", {31'h0, seen}, 32'd0);
        check("flush:if_data", if_data, prev);
        check("flush:done_count", 32'(n_if_done), 32'(kd));

        // Reset after the second byte of a word store
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3;
        mem_addr = 32'h300; mem_wdata = 32'h0102_0304;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid:ram_wr", {31'h0, ram_wr}, 32'd0);
        check("rst_mid:busy", {31'h0, busy}, 32'd0);
        rst = 1'b0; mem_req = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mem_done || busy) seen = 1'b1;
        end
        check("rst_mid:idle", {31'h0, seen}, 32'd0);
        check("rst_mid:byte2", {24'h0, ram[12'h302]}, 32'd0);
        check("rst_mid:if_data", if_data, 32'd0);
        run_txn('{1'b0, 1'b1, 2'd3, 32'h300, 32'h0102_0304, 32'h0}, "fresh_store");
        run_txn('{1'b0, 1'b0, 2'd3, 32'h300, 32'h0,         32'h0102_0304}, "fresh_load");
        run_txn('{1'b1, 1'b0, 2'd3, 32'h100, 32'h0,         32'h0010_0513}, "fresh_fetch");

        @(posedge clk); #1;
`ifdef ARB_STATS_EN
        check("stats:if_cnt", if_cnt, 32'(n_if_done));
        check("stats:mem_cnt", mem_cnt, 32'(n_mem_done));
`else
        check("stats:if_cnt", if_cnt, 32'd0);
        check("stats:mem_cnt", mem_cnt, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
